grf_scoreboard: RTL and testbench

//  32x32 general register file with a per-register pending scoreboard; the read side of the

---
 rtl/grf_pkg.sv | 17 +
 rtl/grf_pend.sv | 58 +++++
 rtl/grf_scoreboard.sv | 76 +++++++
 tb/tb_grf_scoreboard.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/grf_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : grf_pkg                                                         |
// | Brief  : Shared widths and index/word types for the GRF scoreboard       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
package grf_pkg;
  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [DATA_W-1:0] word_t;

  localparam reg_idx_t ZERO_REG = '0;
endpackage : grf_pkg
`default_nettype wire

// File: rtl/grf_pend.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : grf_pend                                                        |
// | Brief  : Per-register pending bits plus registered popcount              |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module grf_pend #(
  parameter int ADDR_W = grf_pkg::ADDR_W
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   iss_en,
  input  logic [ADDR_W-1:0]      iss_a,
  input  logic                   we,
  input  logic [ADDR_W-1:0]      wa,
  output logic [2**ADDR_W-1:0]   pend,
  output logic [ADDR_W:0]        pend_cnt
);
  import grf_pkg::*;

  localparam int c_DEPTH = 2**ADDR_W;

  logic [c_DEPTH-1:0] r_pend;
  logic [c_DEPTH-1:0] w_pend_nxt;
  logic [ADDR_W:0]    r_cnt;
  logic [ADDR_W:0]    w_cnt_nxt;

  // Issue is applied after writeback so a same-index collision leaves the bit set.
  always_comb begin
    w_pend_nxt = r_pend;
    if (we && (wa != ADDR_W'(ZERO_REG)))
      w_pend_nxt[wa] = 1'b0;
    if (iss_en && (iss_a != ADDR_W'(ZERO_REG)))
      w_pend_nxt[iss_a] = 1'b1;
    w_pend_nxt[0] = 1'b0;
  end

  always_comb begin
    w_cnt_nxt = '0;
    for (int i = 1; i < c_DEPTH; i++)
      w_cnt_nxt = w_cnt_nxt + {{ADDR_W{1'b0}}, w_pend_nxt[i]};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_pend <= '0;
      r_cnt  <= '0;
    end else begin
      r_pend <= w_pend_nxt;
      r_cnt  <= w_cnt_nxt;
    end
  end

  assign pend     = r_pend;
  assign pend_cnt = r_cnt;
endmodule : grf_pend
`default_nettype wire

// File: rtl/grf_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : grf_scoreboard                                                  |
// | Brief  : 32x32 register file with pending scoreboard and ready flags.    |
// |          Define GRF_BYPASS_EN for same-cycle writeback forwarding.       |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module grf_scoreboard #(
  parameter int DATA_W = grf_pkg::DATA_W,
  parameter int ADDR_W = grf_pkg::ADDR_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  output logic [DATA_W-1:0] rd1,
  output logic [DATA_W-1:0] rd2,
  output logic              rdy1,
  output logic              rdy2,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_a,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [DATA_W-1:0] wd,
  output logic [ADDR_W:0]   pend_cnt
);
  import grf_pkg::*;

  localparam int c_DEPTH = 2**ADDR_W;

  logic [DATA_W-1:0]  r_mem [c_DEPTH];
  logic [c_DEPTH-1:0] w_pend;
  logic               w_zero1;
  logic               w_zero2;
  logic               w_hit1;
  logic               w_hit2;

  grf_pend #(.ADDR_W(ADDR_W)) u_pend (
    .clk      (clk),
    .reset    (reset),
    .iss_en   (iss_en),
    .iss_a    (iss_a),
    .we       (we),
    .wa       (wa),
    .pend     (w_pend),
    .pend_cnt (pend_cnt)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < c_DEPTH; i++)
        r_mem[i] <= '0;
    end else if (we && (wa != ADDR_W'(ZERO_REG))) begin
      r_mem[wa] <= wd;
    end
  end

  assign w_zero1 = (ra1 == ADDR_W'(ZERO_REG));
  assign w_zero2 = (ra2 == ADDR_W'(ZERO_REG));

`ifdef GRF_BYPASS_EN
  assign w_hit1 = we && (wa == ra1) && !w_zero1;
  assign w_hit2 = we && (wa == ra2) && !w_zero2;
`else
  assign w_hit1 = 1'b0;
  assign w_hit2 = 1'b0;
`endif

  // Index 0 is forced to zero on read rather than relying on its storage.
  assign rd1  = w_zero1 ? '0 : (w_hit1 ? wd : r_mem[ra1]);
  assign rd2  = w_zero2 ? '0 : (w_hit2 ? wd : r_mem[ra2]);
  assign rdy1 = w_zero1 | ~w_pend[ra1] | w_hit1;
  assign rdy2 = w_zero2 | ~w_pend[ra2] | w_hit2;
endmodule : grf_scoreboard
`default_nettype wire

// File: tb/tb_grf_scoreboard.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module : tb_grf_scoreboard                                               |
// | Brief  : Directed self-checking bench; expectations follow GRF_BYPASS_EN |
// | Rev    : 1.0  initial release                                            |
// +--------------------------------------------------------------------------+
module tb_grf_scoreboard;
  logic        clk;
  logic        reset;
  logic [4:0]  ra1, ra2, iss_a, wa;
  logic [31:0] rd1, rd2, wd;
  logic        rdy1, rdy2, iss_en, we;
  logic [5:0]  pend_cnt;

  int n_checks = 0;
  int n_pass   = 0;

`ifdef GRF_BYPASS_EN
  localparam bit c_BYP = 1'b1;
`else
  localparam bit c_BYP = 1'b0;
`endif

  grf_scoreboard dut (
    .clk      (clk),
    .reset    (reset),
    .ra1      (ra1),
    .ra2      (ra2),
    .rd1      (rd1),
    .rd2      (rd2),
    .rdy1     (rdy1),
    .rdy2     (rdy2),
    .iss_en   (iss_en),
    .iss_a    (iss_a),
    .we       (we),
    .wa       (wa),
    .wd       (wd),
    .pend_cnt (pend_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Advance past the next rising edge and let outputs settle.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    we = 1'b0; iss_en = 1'b0; wa = '0; wd = '0; iss_a = '0;
  endtask

  initial begin
    reset = 1'b0; idle(); ra1 = 5'd0; ra2 = 5'd0;
    #12;
    check("rst_rd1", rd1, 32'h0);
    check("rst_rdy1", {31'b0, rdy1}, 32'h1);
    check("rst_cnt", {26'b0, pend_cnt}, 32'h0);
    @(negedge clk); reset = 1'b1;

    // Write then read back
    we = 1'b1; wa = 5'd5; wd = 32'hDEADBEEF; ra1 = 5'd5; #1;
    check("wr_pre_rd1", rd1, c_BYP ? 32'hDEADBEEF : 32'h0);
    tick(); idle(); #1;
    check("wr_rd1", rd1, 32'hDEADBEEF);
    check("wr_rdy1", {31'b0, rdy1}, 32'h1);

    // Register zero ignores writes and issues
    we = 1'b1; wa = 5'd0; wd = 32'h1234; iss_en = 1'b1; iss_a = 5'd0; ra1 = 5'd0;
    tick(); idle(); #1;
    check("zero_rd1", rd1, 32'h0);
    check("zero_rdy1", {31'b0, rdy1}, 32'h1);
    check("zero_cnt", {26'b0, pend_cnt}, 32'h0);

    // Scoreboard issue / writeback on 7
    iss_en = 1'b1; iss_a = 5'd7; tick(); idle(); ra2 = 5'd7; #1;
    check("iss7_rdy2", {31'b0, rdy2}, 32'h0);
    check("iss7_cnt", {26'b0, pend_cnt}, 32'h1);
    we = 1'b1; wa = 5'd7; wd = 32'h9; #1;
    check("wb7_same_rdy2", {31'b0, rdy2}, c_BYP ? 32'h1 : 32'h0);
    check("wb7_same_rd2", rd2, c_BYP ? 32'h9 : 32'h0);
    tick(); idle(); #1;
    check("wb7_rdy2", {31'b0, rdy2}, 32'h1);
    check("wb7_rd2", rd2, 32'h9);
    check("wb7_cnt", {26'b0, pend_cnt}, 32'h0);

    // Collision: issue and writeback to pending index 3 on the same edge
    iss_en = 1'b1; iss_a = 5'd3; tick(); idle(); #1;
    check("iss3_cnt", {26'b0, pend_cnt}, 32'h1);
    iss_en = 1'b1; iss_a = 5'd3; we = 1'b1; wa = 5'd3; wd = 32'hA5;
    tick(); idle(); ra1 = 5'd3; #1;
    check("coll_rd1", rd1, 32'hA5);
    check("coll_rdy1", {31'b0, rdy1}, 32'h0);
    check("coll_cnt", {26'b0, pend_cnt}, 32'h1);

    // Re-issue pending 3, writeback non-pending 5: count must not move
    iss_en = 1'b1; iss_a = 5'd3; tick(); idle(); #1;
    check("reiss_cnt", {26'b0, pend_cnt}, 32'h1);
    we = 1'b1; wa = 5'd5; wd = 32'h77; tick(); idle(); ra2 = 5'd5; #1;
    check("wbnp_cnt", {26'b0, pend_cnt}, 32'h1);
    check("wbnp_rd2", rd2, 32'h77);
    we = 1'b1; wa = 5'd3; wd = 32'hB6; tick(); idle(); #1;
    check("clr3_cnt", {26'b0, pend_cnt}, 32'h0);
    check("clr3_rdy1", {31'b0, rdy1}, 32'h1);

    // Bypass on 12 with both read ports
    we = 1'b1; wa = 5'd12; wd = 32'h11; tick(); idle();
    we = 1'b1; wa = 5'd12; wd = 32'h55; ra1 = 5'd12; ra2 = 5'd12; #1;
    check("byp_rd1", rd1, c_BYP ? 32'h55 : 32'h11);
    check("byp_rd2", rd2, c_BYP ? 32'h55 : 32'h11);
    tick(); idle(); #1;
    check("byp_after_rd1", rd1, 32'h55);

    // Several pending, including the top index
    iss_en = 1'b1; iss_a = 5'd1;  tick();
    iss_a = 5'd2;  tick();
    iss_a = 5'd31; tick(); idle(); ra2 = 5'd31; #1;
    check("multi_cnt", {26'b0, pend_cnt}, 32'h3);
    check("multi_rdy2", {31'b0, rdy2}, 32'h0);

    // Asynchronous reset mid-cycle with an issue in flight
    @(negedge clk); iss_en = 1'b1; iss_a = 5'd9; #2;
    reset = 1'b0; #1;
    check("arst_rd1", rd1, 32'h0);
    check("arst_rdy2", {31'b0, rdy2}, 32'h1);
    check("arst_cnt", {26'b0, pend_cnt}, 32'h0);
    @(negedge clk); idle(); reset = 1'b1;
    tick(); ra1 = 5'd5; #1;
    check("post_rst_cnt", {26'b0, pend_cnt}, 32'h0);
    check("post_rst_rd1", rd1, 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule : tb_grf_scoreboard
`default_nettype wire
